// File: rtl/miriscv_timer.sv
// ---------------------------------------------------------------------------
// miriscv_timer
//   Memory-mapped timer peripheral sitting on the core data bus as a
//   responder. A programmable prescaler produces ticks that advance a
//   32-bit up-counter; when the counter equals the compare value on a tick a
//   match event is raised, optionally reloading the counter and/or stopping
//   the timer (one-shot). The match flag drives a level interrupt request
//   that is cleared by the interrupt controller acknowledge or by software.
//
// Ports
//   clk_i      : clock, all state updates on the rising edge
//   rst_n_i    : asynchronous active-low reset
//   req_i      : bus request, already qualified by the address decoder
//   we_i       : 1 = write, 0 = read
//   be_i       : write byte enables, be_i[n] covers wdata_i[8n+7:8n]
//   addr_i     : byte address, only addr_i[4:2] is decoded
//   wdata_i    : write data
//   rdata_o    : registered read data, valid the cycle after a read request
//   int_req_o  : interrupt request level (MATCH & IE)
//   int_fin_i  : one-cycle interrupt acknowledge, clears MATCH
//
// Register map (offset: name)
//   0x00 CTRL   [0]EN [1]AUTO_RELOAD [2]IE [3]ONE_SHOT
//   0x04 PRESC  [PRESC_WIDTH-1:0]
//   0x08 COUNT  32-bit counter
//   0x0C CMP    32-bit compare value
//   0x10 STATUS [0]MATCH, write-one-to-clear
//   0x14-0x1C   read as zero, writes ignored
// ---------------------------------------------------------------------------
module miriscv_timer #(
  parameter int          PRESC_WIDTH = 16,
  parameter logic [31:0] CMP_RST     = 32'hFFFF_FFFF
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        int_req_o,
  input  logic        int_fin_i
);

  typedef enum logic [2:0] {
    REG_CTRL   = 3'd0,
    REG_PRESC  = 3'd1,
    REG_COUNT  = 3'd2,
    REG_CMP    = 3'd3,
    REG_STATUS = 3'd4
  } reg_sel_e;

  logic [3:0]             ctrl_q;
  logic [PRESC_WIDTH-1:0] presc_q;
  logic [PRESC_WIDTH-1:0] pcnt_q;
  logic [31:0]            count_q;
  logic [31:0]            cmp_q;
  logic                   match_q;

  logic        wr_en;
  logic        rd_en;
  logic [2:0]  sel;
  logic [31:0] wmask;
  logic        wr_ctrl;
  logic        wr_presc;
  logic        wr_count;
  logic        wr_cmp;
  logic        w1c_match;
  logic        tick;
  logic        match_evt;
  logic [31:0] presc_ext;
  logic [31:0] rd_val;

  // Address bits outside [4:2] are decoded upstream; fold them away here.
  logic unused_addr;
  assign unused_addr = ^{addr_i[31:5], addr_i[1:0]};

  // Bus decode: byte-enable mask and per-register write strobes.
  always_comb begin
    wr_en     = req_i & we_i;
    rd_en     = req_i & ~we_i;
    sel       = addr_i[4:2];
    wmask     = {{8{be_i[3]}}, {8{be_i[2]}}, {8{be_i[1]}}, {8{be_i[0]}}};
    wr_ctrl   = wr_en && (sel == REG_CTRL);
    wr_presc  = wr_en && (sel == REG_PRESC);
    wr_count  = wr_en && (sel == REG_COUNT);
    wr_cmp    = wr_en && (sel == REG_CMP);
    w1c_match = wr_en && (sel == REG_STATUS) && be_i[0] && wdata_i[0];
  end

  // A tick fires on the last cycle of each PRESC+1 cycle period; a match
  // only counts when it coincides with a tick.
  assign tick      = ctrl_q[0] && (pcnt_q == presc_q);
  assign match_evt = tick && (count_q == cmp_q);

  // Prescaler counter: idles at zero while disabled and restarts on any
  // PRESC write so a new period always begins from a clean phase.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pcnt_q <= '0;
    end else if (wr_presc || !ctrl_q[0] || tick) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_q + 1'b1;
    end
  end

  // CTRL: a bus write wins over the one-shot self-disable.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ctrl_q <= '0;
    end else if (wr_ctrl) begin
      ctrl_q <= (ctrl_q & ~wmask[3:0]) | (wdata_i[3:0] & wmask[3:0]);
    end else if (match_evt && ctrl_q[3]) begin
      ctrl_q[0] <= 1'b0;
    end
  end

  // PRESC and CMP are plain byte-maskable registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      presc_q <= '0;
      cmp_q   <= CMP_RST;
    end else begin
      if (wr_presc) begin
        presc_q <= (presc_q & ~wmask[PRESC_WIDTH-1:0]) |
                   (wdata_i[PRESC_WIDTH-1:0] & wmask[PRESC_WIDTH-1:0]);
      end
      if (wr_cmp) begin
        cmp_q <= (cmp_q & ~wmask) | (wdata_i & wmask);
      end
    end
  end

  // COUNT: a bus write overrides the tick update; the tick increment wraps
  // silently modulo 2^32 and reloads to zero on a match in auto-reload mode.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
    end else if (wr_count) begin
      count_q <= (count_q & ~wmask) | (wdata_i & wmask);
    end else if (tick) begin
      if (match_evt && ctrl_q[1]) begin
        count_q <= '0;
      end else begin
        count_q <= count_q + 32'd1;
      end
    end
  end

  // MATCH: setting has priority over both the acknowledge and the W1C clear,
  // so a match landing in the same cycle is never lost.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      match_q <= 1'b0;
    end else if (match_evt) begin
      match_q <= 1'b1;
    end else if (int_fin_i || w1c_match) begin
      match_q <= 1'b0;
    end
  end

  // Read mux over the current register values; unmapped offsets read zero.
  always_comb begin
    presc_ext                   = '0;
    presc_ext[PRESC_WIDTH-1:0]  = presc_q;
    rd_val                      = '0;
    case (sel)
      REG_CTRL:   rd_val = {28'd0, ctrl_q};
      REG_PRESC:  rd_val = presc_ext;
      REG_COUNT:  rd_val = count_q;
      REG_CMP:    rd_val = cmp_q;
      REG_STATUS: rd_val = {31'd0, match_q};
      default:    rd_val = '0;
    endcase
  end

  // Read data register: captures on a read, otherwise holds.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rdata_o <= '0;
    end else if (rd_en) begin
      rdata_o <= rd_val;
    end
  end

  assign int_req_o = match_q & ctrl_q[2];

endmodule

// File: tb/tb_miriscv_timer.sv
// ---------------------------------------------------------------------------
// tb_miriscv_timer
//   Self-checking bench for miriscv_timer. Directed scenarios plus a random
//   bus/acknowledge sequence, all compared against a behavioural register
//   model kept in this file, plus literal expectations for the directed cases.
// ---------------------------------------------------------------------------
module tb_miriscv_timer;

  localparam logic [31:0] A_CTRL   = 32'h00;
  localparam logic [31:0] A_PRESC  = 32'h04;
  localparam logic [31:0] A_COUNT  = 32'h08;
  localparam logic [31:0] A_CMP    = 32'h0C;
  localparam logic [31:0] A_STATUS = 32'h10;
  localparam logic [31:0] PRESC_MASK = 32'h0000_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  be = 4'h0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        int_req;
  logic        int_fin = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state
  logic [31:0] m_ctrl, m_presc, m_count, m_cmp, m_rdata;
  logic        m_match;
  int unsigned m_pcnt;

  always #5 clk = ~clk;

  miriscv_timer #(.PRESC_WIDTH(16), .CMP_RST(32'hFFFF_FFFF)) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .req_i    (req),
    .we_i     (we),
    .be_i     (be),
    .addr_i   (addr),
    .wdata_i  (wdata),
    .rdata_o  (rdata),
    .int_req_o(int_req),
    .int_fin_i(int_fin)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] b);
    for (int i = 0; i < 4; i++)
      if (b[i]) old[i*8 +: 8] = d[i*8 +: 8];
    return old;
  endfunction

  task automatic model_reset();
    m_ctrl = 0; m_presc = 0; m_count = 0; m_cmp = 32'hFFFF_FFFF;
    m_match = 0; m_pcnt = 0; m_rdata = 0;
  endtask

  // One clock edge of the register-level behaviour, using the inputs
  // currently on the bus.
  task automatic model_edge();
    bit wr, rd, running, tick, hit;
    int idx;
    logic [31:0] old_count, old_ctrl;
    wr = req && we;
    rd = req && !we;
    idx = int'(addr[4:2]);
    running = m_ctrl[0];
    tick = running && (m_pcnt == m_presc);
    hit = tick && (m_count == m_cmp);
    old_count = m_count;
    old_ctrl = m_ctrl;
    if (rd) begin
      case (idx)
        0: m_rdata = m_ctrl;
        1: m_rdata = m_presc;
        2: m_rdata = m_count;
        3: m_rdata = m_cmp;
        4: m_rdata = {31'd0, m_match};
        default: m_rdata = 0;
      endcase
    end
    if ((wr && idx == 1) || !running || tick) m_pcnt = 0;
    else m_pcnt = m_pcnt + 1;
    if (tick) m_count = (hit && m_ctrl[1]) ? 32'd0 : m_count + 32'd1;
    if (wr && idx == 2) m_count = merge(old_count, wdata, be);
    if (hit && m_ctrl[3]) m_ctrl[0] = 1'b0;
    if (wr && idx == 0) m_ctrl = merge(old_ctrl, wdata, be) & 32'hF;
    if (wr && idx == 1) m_presc = merge(m_presc, wdata, be) & PRESC_MASK;
    if (wr && idx == 3) m_cmp = merge(m_cmp, wdata, be);
    if (hit) m_match = 1'b1;
    else if (int_fin || (wr && idx == 4 && be[0] && wdata[0])) m_match = 1'b0;
  endtask

  task automatic clock_cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic bus(input logic r, input logic w, input logic [3:0] b,
                     input logic [31:0] a, input logic [31:0] d, input logic f);
    req = r; we = w; be = b; addr = a; wdata = d; int_fin = f;
    clock_cycle();
    req = 0; we = 0; be = 0; int_fin = 0;
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
    bus(1'b1, 1'b1, 4'hF, a, d, 1'b0);
  endtask

  task automatic rd_reg(input logic [31:0] a);
    bus(1'b1, 1'b0, 4'h0, a, 32'd0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus(1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b0);
  endtask

  // Stop the timer and return the writable state to a known baseline.
  task automatic quiesce();
    wr_reg(A_CTRL, 32'd0);
    wr_reg(A_STATUS, 32'd1);
    wr_reg(A_COUNT, 32'd0);
    wr_reg(A_PRESC, 32'd0);
  endtask

  task automatic test_reset();
    logic [31:0] exp_rst [8];
    exp_rst = '{32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0};
    rst_n = 0;
    repeat (3) @(negedge clk);
    vectors++;
    if (rdata !== 32'd0 || int_req !== 1'b0) begin
      $display("[TB] FAIL reset_outputs: rdata=%h int_req=%b required 0/0", rdata, int_req);
      miscompares++;
    end
    rst_n = 1;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      rd_reg(32'(i * 4));
      vectors++;
      if (rdata !== exp_rst[i]) begin
        $display("[TB] FAIL reset_read_%0h: got %h required %h", i * 4, rdata, exp_rst[i]);
        miscompares++;
      end
    end
    rd_reg(A_CMP);
    idle(2);
    vectors++;
    if (rdata !== 32'hFFFF_FFFF) begin
      $display("[TB] FAIL rdata_hold: got %h required ffffffff", rdata);
      miscompares++;
    end
  endtask

  task automatic test_auto_reload();
    quiesce();
    wr_reg(A_PRESC, 32'd0);
    wr_reg(A_CMP, 32'd3);
    wr_reg(A_CTRL, 32'h7);
    for (int i = 0; i < 12; i++) begin
      rd_reg(A_COUNT);
      vectors++;
      if (rdata !== m_rdata || rdata !== 32'(i % 4) || int_req !== (m_match & m_ctrl[2])) begin
        $display("[TB] FAIL autoreload_%0d: count=%h int_req=%b required %h/%b",
                 i, rdata, int_req, 32'(i % 4), m_match & m_ctrl[2]);
        miscompares++;
      end
    end
    wr_reg(A_CTRL, 32'h6);
    vectors++;
    if (int_req !== 1'b1) begin
      $display("[TB] FAIL autoreload_irq: int_req=%b required 1", int_req);
      miscompares++;
    end
    bus(1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b1);
    vectors++;
    if (int_req !== 1'b0) begin
      $display("[TB] FAIL int_fin_clear: int_req=%b required 0", int_req);
      miscompares++;
    end
  endtask

  task automatic test_one_shot();
    quiesce();
    wr_reg(A_PRESC, 32'd4);
    wr_reg(A_CMP, 32'd2);
    wr_reg(A_CTRL, 32'h9);
    for (int i = 0; i < 30; i++) begin
      rd_reg(A_COUNT);
      vectors++;
      if (rdata !== m_rdata) begin
        $display("[TB] FAIL oneshot_count_%0d: got %h required %h", i, rdata, m_rdata);
        miscompares++;
      end
    end
    rd_reg(A_COUNT);
    vectors++;
    if (rdata !== 32'd3) begin
      $display("[TB] FAIL oneshot_frozen: got %h required 3", rdata);
      miscompares++;
    end
    rd_reg(A_CTRL);
    vectors++;
    if (rdata !== 32'h8) begin
      $display("[TB] FAIL oneshot_ctrl: got %h required 8", rdata);
      miscompares++;
    end
    rd_reg(A_STATUS);
    vectors++;
    if (rdata !== 32'd1 || int_req !== 1'b0) begin
      $display("[TB] FAIL oneshot_status: status=%h int_req=%b required 1/0", rdata, int_req);
      miscompares++;
    end
  endtask

  task automatic test_wrap();
    quiesce();
    wr_reg(A_CMP, 32'd5);
    wr_reg(A_COUNT, 32'hFFFF_FFFE);
    wr_reg(A_CTRL, 32'h1);
    for (int i = 0; i < 6; i++) begin
      rd_reg(A_COUNT);
      vectors++;
      if (rdata !== 32'hFFFF_FFFE + 32'(i)) begin
        $display("[TB] FAIL wrap_%0d: got %h required %h", i, rdata, 32'hFFFF_FFFE + 32'(i));
        miscompares++;
      end
    end
    rd_reg(A_STATUS);
    vectors++;
    if (rdata !== 32'd0) begin
      $display("[TB] FAIL wrap_no_match: got %h required 0", rdata);
      miscompares++;
    end
    rd_reg(A_COUNT);
    rd_reg(A_STATUS);
    vectors++;
    if (rdata !== 32'd1) begin
      $display("[TB] FAIL wrap_match: got %h required 1", rdata);
      miscompares++;
    end
  endtask

  task automatic test_same_cycle();
    quiesce();
    wr_reg(A_CMP, 32'h1000);
    wr_reg(A_CTRL, 32'h1);
    idle(2);
    wr_reg(A_COUNT, 32'h10);
    rd_reg(A_COUNT);
    vectors++;
    if (rdata !== 32'h10) begin
      $display("[TB] FAIL count_write_beats_tick: got %h required 10", rdata);
      miscompares++;
    end
    quiesce();
    wr_reg(A_CMP, 32'd5);
    wr_reg(A_COUNT, 32'd5);
    wr_reg(A_CTRL, 32'h1);
    bus(1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b1);
    rd_reg(A_STATUS);
    vectors++;
    if (rdata !== 32'd1) begin
      $display("[TB] FAIL match_beats_fin: got %h required 1", rdata);
      miscompares++;
    end
    wr_reg(A_CTRL, 32'h0);
    wr_reg(A_STATUS, 32'h1);
    rd_reg(A_STATUS);
    vectors++;
    if (rdata !== 32'd0) begin
      $display("[TB] FAIL w1c_clear: got %h required 0", rdata);
      miscompares++;
    end
    wr_reg(A_COUNT, 32'd5);
    wr_reg(A_CTRL, 32'h1);
    bus(1'b1, 1'b1, 4'b0001, A_STATUS, 32'h1, 1'b0);
    rd_reg(A_STATUS);
    vectors++;
    if (rdata !== 32'd1) begin
      $display("[TB] FAIL match_beats_w1c: got %h required 1", rdata);
      miscompares++;
    end
    wr_reg(A_CTRL, 32'h0);
    wr_reg(A_CMP, 32'h1122_3344);
    bus(1'b1, 1'b1, 4'b0010, A_CMP, 32'hAABB_CCDD, 1'b0);
    rd_reg(A_CMP);
    vectors++;
    if (rdata !== 32'h1122_CC44) begin
      $display("[TB] FAIL byte_enable: got %h required 1122cc44", rdata);
      miscompares++;
    end
    wr_reg(A_PRESC, 32'hFFFF_FFFF);
    rd_reg(A_PRESC);
    vectors++;
    if (rdata !== 32'h0000_FFFF) begin
      $display("[TB] FAIL presc_width: got %h required 0000ffff", rdata);
      miscompares++;
    end
    wr_reg(A_CTRL, 32'hFFFF_FFF0);
    rd_reg(A_CTRL);
    vectors++;
    if (rdata !== 32'd0) begin
      $display("[TB] FAIL ctrl_upper: got %h required 0", rdata);
      miscompares++;
    end
  endtask

  task automatic test_random();
    logic        r, w, f;
    logic [3:0]  b;
    logic [31:0] a, d;
    int          idx;
    quiesce();
    for (int i = 0; i < 400; i++) begin
      idx = $urandom_range(0, 7);
      r = ($urandom_range(0, 3) != 0);
      w = $urandom_range(0, 1);
      b = 4'($urandom);
      a = $urandom;
      a[4:2] = 3'(idx);
      case (idx)
        1: d = $urandom_range(0, 3);
        2, 3: d = $urandom_range(0, 12);
        default: d = $urandom;
      endcase
      f = ($urandom_range(0, 7) == 0);
      bus(r, w, b, a, d, f);
      vectors++;
      if (rdata !== m_rdata || int_req !== (m_match & m_ctrl[2])) begin
        $display("[TB] FAIL random_%0d: rdata=%h int_req=%b required %h/%b",
                 i, rdata, int_req, m_rdata, m_match & m_ctrl[2]);
        miscompares++;
      end
    end
  endtask

  task automatic test_async_reset();
    quiesce();
    wr_reg(A_CMP, 32'd6);
    wr_reg(A_COUNT, 32'd6);
    wr_reg(A_CTRL, 32'hD);
    idle(1);
    rd_reg(A_COUNT);
    vectors++;
    if (rdata !== 32'd7 || int_req !== 1'b1) begin
      $display("[TB] FAIL pre_reset_state: count=%h int_req=%b required 7/1", rdata, int_req);
      miscompares++;
    end
    #2 rst_n = 0;
    #1;
    vectors++;
    if (rdata !== 32'd0 || int_req !== 1'b0) begin
      $display("[TB] FAIL async_reset: rdata=%h int_req=%b required 0/0", rdata, int_req);
      miscompares++;
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    rd_reg(A_COUNT);
    vectors++;
    if (rdata !== 32'd0) begin
      $display("[TB] FAIL post_reset_count: got %h required 0", rdata);
      miscompares++;
    end
    rd_reg(A_STATUS);
    vectors++;
    if (rdata !== 32'd0 || int_req !== 1'b0) begin
      $display("[TB] FAIL post_reset_status: status=%h int_req=%b required 0/0", rdata, int_req);
      miscompares++;
    end
    rd_reg(A_CMP);
    vectors++;
    if (rdata !== 32'hFFFF_FFFF) begin
      $display("[TB] FAIL post_reset_cmp: got %h required ffffffff", rdata);
      miscompares++;
    end
    rd_reg(A_CTRL);
    vectors++;
    if (rdata !== 32'd0) begin
      $display("[TB] FAIL post_reset_ctrl: got %h required 0", rdata);
      miscompares++;
    end
  endtask

  initial begin
    model_reset();
    $display("[TB] miriscv_timer bench start");
    test_reset();
    test_auto_reload();
    test_one_shot();
    test_wrap();
    test_same_cycle();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
